// File: rtl/amp_scan_pkg.sv
// Shared types and default sizing for the amplifier scan sequencer.
package amp_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam int NUM_CH_DEF   = 4;
    localparam int SETTLE_W_DEF = 8;
    localparam int ACC_W_DEF    = 4;

endpackage

// File: rtl/amp_scan_sync.sv
// Two-flop synchroniser bringing the comparator output into the clk domain.
module amp_scan_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk) begin
        if (rst) ff_q <= 2'b00;
        else     ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/amp_scan_seq.sv
// Amplifier channel scan sequencer: settle, sample comparator, report majority.
// Define AMP_SCAN_CONT_EN to wrap back to the lowest channel forever.
module amp_scan_seq
    import amp_scan_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic [SETTLE_W-1:0]       settle_cycles,
    input  logic [ACC_W-1:0]          n_samples,
    input  logic                      cmp_in,
    input  logic                      res_ready,
    output logic                      amp_en,
    output logic [$clog2(NUM_CH)-1:0] mux_sel,
    output logic                      busy,
    output logic                      res_valid,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [ACC_W-1:0]          res_count,
    output logic                      res_bit
);

    localparam int CH_W = $clog2(NUM_CH);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] scnt_q, scnt_d;
    logic [ACC_W-1:0]    nsamp_q, nsamp_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    idx_q, idx_d;
    logic [CH_W-1:0]     mux_q, mux_d;
    logic [CH_W-1:0]     rch_q, rch_d;
    logic [ACC_W-1:0]    rcnt_q, rcnt_d;
    logic                rbit_q, rbit_d;

    logic                cmp_s;
    logic [SETTLE_W-1:0] settle_eff;
    logic [ACC_W-1:0]    n_eff;
    logic [ACC_W-1:0]    sum;
    logic                maj;
    logic                hi_found;
    logic [CH_W-1:0]     hi_ch, lo_ch, st_ch;

    amp_scan_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (cmp_in),
        .q_o (cmp_s)
    );

    assign settle_eff = (settle_q == '0) ? SETTLE_W'(1) : settle_q;
    assign n_eff      = (nsamp_q == '0) ? ACC_W'(1) : nsamp_q;
    assign sum        = acc_q + ACC_W'(cmp_s);
    // Tie (2*count == n) must resolve to 0, hence strict compare.
    assign maj        = {sum, 1'b0} > {1'b0, n_eff};

    always_comb begin
        hi_found = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        st_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lo_ch = CH_W'(i);
                if (i > int'(mux_q)) begin
                    hi_found = 1'b1;
                    hi_ch    = CH_W'(i);
                end
            end
            if (ch_mask[i]) st_ch = CH_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        settle_d = settle_q;
        nsamp_d  = nsamp_q;
        scnt_d   = scnt_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        mux_d    = mux_q;
        rch_d    = rch_q;
        rcnt_d   = rcnt_q;
        rbit_d   = rbit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && (ch_mask != '0)) begin
                    mask_d   = ch_mask;
                    settle_d = settle_cycles;
                    nsamp_d  = n_samples;
                    mux_d    = st_ch;
                    scnt_d   = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == settle_eff - SETTLE_W'(1)) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    scnt_d = scnt_q + SETTLE_W'(1);
                end
            end
            ST_SAMPLE: begin
                acc_d = sum;
                idx_d = idx_q + ACC_W'(1);
                if (idx_q == n_eff - ACC_W'(1)) begin
                    rcnt_d  = sum;
                    rbit_d  = maj;
                    rch_d   = mux_q;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    scnt_d = '0;
                    if (hi_found) begin
                        mux_d   = hi_ch;
                        state_d = ST_SETTLE;
                    end else begin
`ifdef AMP_SCAN_CONT_EN
                        mux_d   = lo_ch;
                        state_d = ST_SETTLE;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            settle_q <= '0;
            nsamp_q  <= '0;
            scnt_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            mux_q    <= '0;
            rch_q    <= '0;
            rcnt_q   <= '0;
            rbit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            settle_q <= settle_d;
            nsamp_q  <= nsamp_d;
            scnt_q   <= scnt_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            mux_q    <= mux_d;
            rch_q    <= rch_d;
            rcnt_q   <= rcnt_d;
            rbit_q   <= rbit_d;
        end
    end

    assign amp_en    = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_REPORT);
    assign mux_sel   = mux_q;
    assign res_ch    = rch_q;
    assign res_count = rcnt_q;
    assign res_bit   = rbit_q;

endmodule
